// File: rtl/sar_pkg.sv
// Shared types and width helpers for the successive-approximation search controller.
package sar_pkg;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} sar_state_t;

  // Step counter must hold 0..n comparisons.
  function automatic int steps_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Bit index k spans 0..n-1; keep at least one bit.
  function automatic int index_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// Binary search of an unknown word that is visible only through a
// comparator (g: unknown > trial, l: unknown < trial). Uses one comparison per clock.
//
// state  | meaning
// IDLE   | waiting for start; trial/result/steps hold
// SEARCH | one comparison per clock, trial refined MSB first
// DONE   | one-cycle done pulse, then IDLE
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      g,
  input  logic                      l,
  output logic [N-1:0]              trial,
  output logic [N-1:0]              result,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [steps_width(N)-1:0] steps
);

  localparam int SW = steps_width(N);
  localparam int KW = index_width(N);
  localparam logic [N-1:0]  ONE        = N'(1);
  localparam logic [N-1:0]  TRIAL_INIT = ONE << (N - 1);
  localparam logic [KW-1:0] K_TOP      = KW'(N - 1);

  sar_state_t    state, state_nx;
  logic [KW-1:0] k, k_nx;
  logic [N-1:0]  trial_nx, result_nx;
  logic [SW-1:0] steps_nx;
  logic          err_nx;
  logic [N-1:0]  bit_k, bit_km1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      trial  <= '0;
      result <= '0;
      steps  <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      k      <= k_nx;
      trial  <= trial_nx;
      result <= result_nx;
      steps  <= steps_nx;
      err    <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    k_nx      = k;
    trial_nx  = trial;
    result_nx = result;
    steps_nx  = steps;
    err_nx    = err;
    bit_k     = ONE << k;
    // Only consumed when k > 0, so the wrap at k == 0 is harmless.
    bit_km1   = ONE << (k - KW'(1));

    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SEARCH;
          trial_nx = TRIAL_INIT;
          k_nx     = K_TOP;
          steps_nx = '0;
          err_nx   = 1'b0;
        end
      end
      SEARCH: begin
        steps_nx = steps + SW'(1);
        if (g && l) begin
          err_nx    = 1'b1;
          result_nx = '0;
          state_nx  = DONE;
        end else if (!g && !l) begin
          result_nx = trial;
          state_nx  = DONE;
        end else if (g) begin
          if (k == '0) begin
            result_nx = trial;
            state_nx  = DONE;
          end else begin
            trial_nx = trial | bit_km1;
            k_nx     = k - KW'(1);
          end
        end else begin
          if (k == '0) begin
            result_nx = trial & ~ONE;
            state_nx  = DONE;
          end else begin
            trial_nx = (trial & ~bit_k) | bit_km1;
            k_nx     = k - KW'(1);
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == SEARCH);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Scoreboard bench for sar_search_ctrl (N=4) against a behavioural 4-bit comparator.
module tb_sar_search_ctrl;

  localparam int N  = 4;
  localparam int SW = 3;

  typedef struct packed {
    logic [N-1:0]  result;
    logic [SW-1:0] steps;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          g, l;
  logic [N-1:0]  trial, result;
  logic          busy, done, err;
  logic [SW-1:0] steps;

  logic [N-1:0]  secret = '0;
  logic          force_gl = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t         res_q[$];
  logic [N-1:0] trial_q[$];

  always #5 clk = ~clk;

  // comparator_Nbit #(4): A = secret, B = trial
  assign g = force_gl ? 1'b1 : (secret > trial);
  assign l = force_gl ? 1'b1 : (secret < trial);

  sar_search_ctrl #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .g      (g),
    .l      (l),
    .trial  (trial),
    .result (result),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .steps  (steps)
  );

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every SEARCH cycle pops an expected trial, every done pops a result.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (busy) begin
      if (trial_q.size() == 0) check("unexpected_search_cycle", 1, 0);
      else check("trial", int'(trial), int'(trial_q.pop_front()));
      check("busy_done_exclusive", int'(done), 0);
    end
    if (done) begin
      check("done_one_cycle", int'(done_prev), 0);
      if (res_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = res_q.pop_front();
        check("result", int'(result), int'(e.result));
        check("steps", int'(steps), int'(e.steps));
        check("err", int'(err), int'(e.err));
      end
    end
    done_prev = done;
  end

  task automatic push_search(input logic [N-1:0] tr[$], input logic [N-1:0] res,
                             input int stp, input logic e);
    exp_t x;
    foreach (tr[i]) trial_q.push_back(tr[i]);
    x.result = res;
    x.steps  = SW'(stp);
    x.err    = e;
    res_q.push_back(x);
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Returns at the negedge where done is high; an expired budget is a failure.
  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check({name, "_done_timeout"}, int'(seen), 1);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_trial"},  int'(trial),  0);
    check({name, "_result"}, int'(result), 0);
    check({name, "_steps"},  int'(steps),  0);
    check({name, "_busy"},   int'(busy),   0);
    check({name, "_done"},   int'(done),   0);
    check({name, "_err"},    int'(err),    0);
  endtask

  initial begin
    #12;
    check_reset_values("por");
    @(negedge clk); rst = 1'b0;

    // secret 10: 8,12,10 then equal
    secret = 4'd10;
    push_search('{4'd8, 4'd12, 4'd10}, 4'd10, 3, 1'b0);
    do_start();
    wait_done("s10", 10);
    @(negedge clk);
    check("s10_idle_busy", int'(busy), 0);
    check("s10_hold_result", int'(result), 10);
    check("s10_hold_trial", int'(trial), 10);

    // async reset mid-search after two compares
    trial_q.push_back(4'd8);
    trial_q.push_back(4'd12);
    do_start();
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_idle_busy", int'(busy), 0);
    check("midrst_idle_done", int'(done), 0);

    // secret 0: all l
    secret = 4'd0;
    push_search('{4'd8, 4'd4, 4'd2, 4'd1}, 4'd0, 4, 1'b0);
    do_start();
    wait_done("s0", 10);

    // secret 15: all g; done width checked by monitor
    secret = 4'd15;
    push_search('{4'd8, 4'd12, 4'd14, 4'd15}, 4'd15, 4, 1'b0);
    do_start();
    wait_done("s15", 10);
    @(negedge clk);
    check("s15_done_low_after", int'(done), 0);

    // illegal g=l=1 on first compare
    force_gl = 1'b1;
    push_search('{4'd8}, 4'd0, 1, 1'b1);
    do_start();
    wait_done("illegal", 10);
    force_gl = 1'b0;
    @(negedge clk);
    check("illegal_err_hold", int'(err), 1);

    // start held high (secret 11): one search, IDLE gap, then a second one
    secret = 4'd11;
    push_search('{4'd8, 4'd12, 4'd10, 4'd11}, 4'd11, 4, 1'b0);
    push_search('{4'd8, 4'd12, 4'd10, 4'd11}, 4'd11, 4, 1'b0);
    @(posedge clk); #1 start = 1'b1;
    wait_done("held1", 10);
    @(negedge clk);
    check("held_idle_gap_busy", int'(busy), 0);
    check("held_idle_gap_done", int'(done), 0);
    check("held_idle_err_cleared", int'(err), 0);
    @(posedge clk); #1 start = 1'b0;
    wait_done("held2", 10);

    repeat (3) @(negedge clk);
    check("trial_queue_empty", trial_q.size(), 0);
    check("result_queue_empty", res_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
